alu_operand_stage: RTL

ID/EX pipeline register and operand-forwarding front end of the execute stage. Captures decoded instruction fields each cycle, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and drives the ALU operand and control inputs (i1, i2, cntrlALU) directly. Also detects load-use hazards, requests a one-cycle front-end stall, and inserts a bubble.

---
 rtl/alu_pkg.sv | 62 ++++++
 rtl/fwd_sel.sv | 40 ++++
 rtl/alu_operand_stage.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU codes, forward selects and ID/EX entry type
//
// Purpose: constants and types shared by the execute-stage operand front end.
// Ports:   none (package).
// Optional feature macro used by importers: ALU_STAGE_LOAD_USE_EN.

package alu_pkg;

   // ALU control codes driven on alu_cntrl
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0010;
   localparam logic [3:0] ALU_AND = 4'b0100;
   localparam logic [3:0] ALU_OR  = 4'b0101;
   localparam logic [3:0] ALU_NOR = 4'b0110;
   localparam logic [3:0] ALU_XOR = 4'b0111;
   localparam logic [3:0] ALU_SLL = 4'b1000;
   localparam logic [3:0] ALU_SRA = 4'b1001;
   localparam logic [3:0] ALU_SRL = 4'b1010;

   // Forwarding source selects
   localparam logic [1:0] FWD_REG   = 2'd0;
   localparam logic [1:0] FWD_EXMEM = 2'd1;
   localparam logic [1:0] FWD_MEMWB = 2'd2;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;

   // One ID/EX pipeline entry; an all-zero value is a bubble
   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] rs_val;
      logic [DATA_W-1:0] rt_val;
      logic [DATA_W-1:0] imm;
      logic [REG_W-1:0]  shamt;
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  dest;
      logic [3:0]        alu_op;
      logic              alu_src;
      logic              shift;
      logic              shift_var;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic              mem_to_reg;
   } idex_t;

   // Pick the forwarded value for a given select
   function automatic logic [DATA_W-1:0] fwd_mux(input logic [1:0]        sel,
                                                 input logic [DATA_W-1:0] reg_val,
                                                 input logic [DATA_W-1:0] exmem_val,
                                                 input logic [DATA_W-1:0] memwb_val);
      logic [DATA_W-1:0] r;
      case (sel)
         FWD_EXMEM: r = exmem_val;
         FWD_MEMWB: r = memwb_val;
         default:   r = reg_val;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - forwarding source select for one operand index
//
// Purpose: decide whether a source register is taken from EX/MEM, MEM/WB or
//          the registered read value. EX/MEM holds the newer result and wins.
//          Register 0 is never forwarded.
// Ports:
//   src_i             : source register index held in EX
//   exmem_reg_write_i : EX/MEM writes a register
//   exmem_rd_i        : EX/MEM destination index
//   memwb_reg_write_i : MEM/WB writes a register
//   memwb_rd_i        : MEM/WB destination index
//   sel_o             : FWD_REG / FWD_EXMEM / FWD_MEMWB

module fwd_sel
   import alu_pkg::*;
(
   input  logic [REG_W-1:0] src_i,
   input  logic             exmem_reg_write_i,
   input  logic [REG_W-1:0] exmem_rd_i,
   input  logic             memwb_reg_write_i,
   input  logic [REG_W-1:0] memwb_rd_i,
   output logic [1:0]       sel_o
);

   logic exmem_hit;
   logic memwb_hit;

   assign exmem_hit = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == src_i);
   assign memwb_hit = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == src_i);

   always_comb begin
      sel_o = FWD_REG;
      if (exmem_hit) begin
         sel_o = FWD_EXMEM;
      end else if (memwb_hit) begin
         sel_o = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ID/EX register with operand forwarding and load-use stall
//
// Purpose: captures decoded ID fields into the EX stage, forwards results from
//          EX/MEM and MEM/WB to resolve RAW hazards, drives ALU operands and
//          control, and (optionally) detects load-use hazards.
// Optional feature: ALU_STAGE_LOAD_USE_EN enables load-use detection and bubble
//          insertion; without it stall_req is 0 and loads need a delay slot.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   hold, flush              : freeze entry / squash to bubble
//   id_*                     : decoded instruction fields from ID
//   exmem_*, memwb_*         : forwarding sources
//   alu_i1, alu_i2, alu_cntrl: ALU operands and control
//   ex_store_data            : forwarded rt for stores
//   ex_dest, ex_rs, ex_rt    : registered register indices
//   ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg : control
//   stall_req                : freeze PC and IF/ID this cycle

module alu_operand_stage
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        hold,
   input  logic        flush,
   input  logic        id_valid,
   input  logic [31:0] id_rs_val,
   input  logic [31:0] id_rt_val,
   input  logic [31:0] id_imm,
   input  logic [4:0]  id_shamt,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [4:0]  id_rd,
   input  logic        id_uses_rs,
   input  logic        id_uses_rt,
   input  logic [3:0]  id_alu_op,
   input  logic        id_alu_src,
   input  logic        id_shift,
   input  logic        id_shift_var,
   input  logic        id_reg_dst,
   input  logic        id_reg_write,
   input  logic        id_mem_read,
   input  logic        id_mem_write,
   input  logic        id_mem_to_reg,
   input  logic        exmem_reg_write,
   input  logic [4:0]  exmem_rd,
   input  logic [31:0] exmem_result,
   input  logic        memwb_reg_write,
   input  logic [4:0]  memwb_rd,
   input  logic [31:0] memwb_result,
   output logic [31:0] alu_i1,
   output logic [31:0] alu_i2,
   output logic [3:0]  alu_cntrl,
   output logic [31:0] ex_store_data,
   output logic [4:0]  ex_dest,
   output logic [4:0]  ex_rs,
   output logic [4:0]  ex_rt,
   output logic        ex_valid,
   output logic        ex_reg_write,
   output logic        ex_mem_read,
   output logic        ex_mem_write,
   output logic        ex_mem_to_reg,
   output logic        stall_req
);

   idex_t       ex_q;
   idex_t       ex_d;
   idex_t       id_entry;
   logic        load_use;
   logic [1:0]  sel_rs;
   logic [1:0]  sel_rt;
   logic [31:0] fwd_rs;
   logic [31:0] fwd_rt;

   // Entry that would be captured from ID this cycle
   always_comb begin
      id_entry            = '0;
      id_entry.valid      = id_valid;
      id_entry.rs_val     = id_rs_val;
      id_entry.rt_val     = id_rt_val;
      id_entry.imm        = id_imm;
      id_entry.shamt      = id_shamt;
      id_entry.rs         = id_rs;
      id_entry.rt         = id_rt;
      id_entry.dest       = id_reg_dst ? id_rd : id_rt;
      id_entry.alu_op     = id_alu_op;
      id_entry.alu_src    = id_alu_src;
      id_entry.shift      = id_shift;
      id_entry.shift_var  = id_shift_var;
      id_entry.reg_write  = id_reg_write;
      id_entry.mem_read   = id_mem_read;
      id_entry.mem_write  = id_mem_write;
      id_entry.mem_to_reg = id_mem_to_reg;
   end

`ifdef ALU_STAGE_LOAD_USE_EN
   // A load in EX cannot forward to the instruction in ID; stall one cycle so
   // the load reaches MEM/WB range when ID is re-presented.
   assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.dest != '0) && id_valid &&
                     ((id_uses_rs && (id_rs == ex_q.dest)) ||
                      (id_uses_rt && (id_rt == ex_q.dest)));
`else
   logic unused_id_uses;
   assign unused_id_uses = id_uses_rs ^ id_uses_rt;
   assign load_use       = 1'b0;
`endif

   assign stall_req = load_use;

   // Capture priority below reset: flush > hold > load-use bubble > load
   always_comb begin
      ex_d = ex_q;
      if (flush) begin
         ex_d = '0;
      end else if (hold) begin
         ex_d = ex_q;
      end else if (load_use) begin
         ex_d = '0;
      end else begin
         ex_d = id_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q <= '0;
      end else begin
         ex_q <= ex_d;
      end
   end

   fwd_sel u_fwd_rs (
      .src_i             (ex_q.rs),
      .exmem_reg_write_i (exmem_reg_write),
      .exmem_rd_i        (exmem_rd),
      .memwb_reg_write_i (memwb_reg_write),
      .memwb_rd_i        (memwb_rd),
      .sel_o             (sel_rs)
   );

   fwd_sel u_fwd_rt (
      .src_i             (ex_q.rt),
      .exmem_reg_write_i (exmem_reg_write),
      .exmem_rd_i        (exmem_rd),
      .memwb_reg_write_i (memwb_reg_write),
      .memwb_rd_i        (memwb_rd),
      .sel_o             (sel_rt)
   );

   assign fwd_rs = fwd_mux(sel_rs, ex_q.rs_val, exmem_result, memwb_result);
   assign fwd_rt = fwd_mux(sel_rt, ex_q.rt_val, exmem_result, memwb_result);

   // Shifts operate on rt; the amount is either shamt or the low bits of rs
   always_comb begin
      alu_i1 = fwd_rs;
      alu_i2 = ex_q.alu_src ? ex_q.imm : fwd_rt;
      if (ex_q.shift) begin
         alu_i1 = fwd_rt;
         alu_i2 = ex_q.shift_var ? {27'b0, fwd_rs[4:0]} : {27'b0, ex_q.shamt};
      end
   end

   assign alu_cntrl     = ex_q.alu_op;
   assign ex_store_data = fwd_rt;
   assign ex_dest       = ex_q.dest;
   assign ex_rs         = ex_q.rs;
   assign ex_rt         = ex_q.rt;
   assign ex_valid      = ex_q.valid;
   assign ex_reg_write  = ex_q.reg_write;
   assign ex_mem_read   = ex_q.mem_read;
   assign ex_mem_write  = ex_q.mem_write;
   assign ex_mem_to_reg = ex_q.mem_to_reg;

endmodule
